// File: rtl/ex_ctl_conv_if.sv
// ex_ctl_conv_if: sequencer and MAC-side signals of the dense/conv execution controller
interface ex_ctl_conv_if #(parameter int CW = 5, IAW = 12, WAW = 10, OAW = 10);
   logic mode, stride;
   logic [CW-1:0] ow_last, oh_last, iw_last, ic_last, k_last;
   logic s_init, out_busy, outrf;
   logic busy, k_init, exec, k_fin, s_fin;
   logic [OAW-1:0] oa;
   logic [IAW-1:0] ia;
   logic [WAW-1:0] wa;
   modport master (output mode, stride, ow_last, oh_last, iw_last, ic_last, k_last, s_init, out_busy, outrf,
                   input busy, k_init, exec, k_fin, s_fin, oa, ia, wa);
   modport slave (input mode, stride, ow_last, oh_last, iw_last, ic_last, k_last, s_init, out_busy, outrf,
                  output busy, k_init, exec, k_fin, s_fin, oa, ia, wa);
endinterface

// File: rtl/ex_ctl_conv.sv
// ex_ctl_conv: walks output positions and inner terms, emitting input/weight addresses per MAC term
module ex_ctl_conv #(parameter int CW = 5, IAW = 12, WAW = 10, OAW = 10) (
   input logic clk,
   input logic rst,
   ex_ctl_conv_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RUN = 2'd2, DRAIN = 2'd3;
   logic [1:0] state_q, state_d;
   logic kreq_q, kreq_d, k_fin_q, k_fin_d, s_fin_q, s_fin_d, stride_q, stride_d;
   logic [CW-1:0] owl_q, owl_d, ohl_q, ohl_d, iwl_q, iwl_d, icl_q, icl_d, kl_q, kl_d;
   logic [CW-1:0] ic_q, ic_d, kx_q, kx_d, ky_q, ky_d, ox_q, ox_d, oy_q, oy_d;
   logic [OAW-1:0] oa_q, oa_d;
   logic ic_end, kx_end, ky_end, ox_end, oy_end, win_end, k_init;
   logic [IAW-1:0] iy, ix;
   assign ic_end = ic_q == icl_q;
   assign kx_end = kx_q == kl_q;
   assign ky_end = ky_q == kl_q;
   assign ox_end = ox_q == owl_q;
   assign oy_end = oy_q == ohl_q;
   assign win_end = ic_end & kx_end & ky_end;
   assign k_init = kreq_q & ~bus.out_busy;
   // dense is conv with a 1x1 window, one output row and stride 1, so one formula serves both
   assign iy = (IAW'(oy_q) << stride_q) + IAW'(ky_q);
   assign ix = (IAW'(ox_q) << stride_q) + IAW'(kx_q);
   assign bus.ia = (iy * (IAW'(iwl_q) + IAW'(1)) + ix) * (IAW'(icl_q) + IAW'(1)) + IAW'(ic_q);
   assign bus.wa = (WAW'(ky_q) * (WAW'(kl_q) + WAW'(1)) + WAW'(kx_q)) * (WAW'(icl_q) + WAW'(1)) + WAW'(ic_q);
   assign bus.oa = oa_q;
   assign bus.k_init = k_init;
   assign bus.exec = state_q == RUN;
   assign bus.k_fin = k_fin_q;
   assign bus.s_fin = s_fin_q;
   assign bus.busy = (state_q != IDLE) | s_fin_q;
   always_comb begin
      state_d = state_q;
      kreq_d = kreq_q;
      k_fin_d = 1'b0;
      s_fin_d = 1'b0;
      oa_d = oa_q;
      {stride_d, owl_d, ohl_d, iwl_d, icl_d, kl_d} = {stride_q, owl_q, ohl_q, iwl_q, icl_q, kl_q};
      {oy_d, ox_d, ky_d, kx_d, ic_d} = {oy_q, ox_q, ky_q, kx_q, ic_q};
      case (state_q)
         IDLE: if (bus.s_init && !s_fin_q) begin
            state_d = WAIT;
            kreq_d = 1'b1;
            stride_d = bus.mode & bus.stride;
            owl_d = bus.ow_last;
            ohl_d = bus.mode ? bus.oh_last : '0;
            iwl_d = bus.iw_last;
            icl_d = bus.ic_last;
            kl_d = bus.mode ? bus.k_last : '0;
         end
         WAIT: if (k_init) begin
            state_d = RUN;
            kreq_d = 1'b0;
         end
         RUN: begin
            ic_d = ic_end ? '0 : ic_q + 1'b1;
            kx_d = !ic_end ? kx_q : kx_end ? '0 : kx_q + 1'b1;
            ky_d = !(ic_end && kx_end) ? ky_q : ky_end ? '0 : ky_q + 1'b1;
            ox_d = !win_end ? ox_q : ox_end ? '0 : ox_q + 1'b1;
            oy_d = !(win_end && ox_end) ? oy_q : oy_end ? '0 : oy_q + 1'b1;
            if (win_end) begin
               k_fin_d = 1'b1;
               oa_d = OAW'(oy_q) * (OAW'(owl_q) + OAW'(1)) + OAW'(ox_q);
               state_d = (ox_end && oy_end) ? DRAIN : WAIT;
               kreq_d = !(ox_end && oy_end);
            end
         end
         default: if (bus.outrf) begin
            s_fin_d = 1'b1;
            state_d = IDLE;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         {kreq_q, k_fin_q, s_fin_q, stride_q} <= '0;
         {owl_q, ohl_q, iwl_q, icl_q, kl_q} <= '0;
         {oy_q, ox_q, ky_q, kx_q, ic_q} <= '0;
         oa_q <= '0;
      end else begin
         state_q <= state_d;
         {kreq_q, k_fin_q, s_fin_q, stride_q} <= {kreq_d, k_fin_d, s_fin_d, stride_d};
         {owl_q, ohl_q, iwl_q, icl_q, kl_q} <= {owl_d, ohl_d, iwl_d, icl_d, kl_d};
         {oy_q, ox_q, ky_q, kx_q, ic_q} <= {oy_d, ox_d, ky_d, kx_d, ic_d};
         oa_q <= oa_d;
      end
   end
endmodule

// File: tb/tb_ex_ctl_conv.sv
// tb_ex_ctl_conv: scoreboarded bench for ex_ctl_conv; a nested-loop model predicts every exec term and window address
module tb_ex_ctl_conv;
   logic clk = 1'b0, rst = 1'b0;
   always #5 clk = ~clk;
   ex_ctl_conv_if #(.CW(5), .IAW(12), .WAW(10), .OAW(10)) ifc();
   ex_ctl_conv #(.CW(5), .IAW(12), .WAW(10), .OAW(10)) dut (.clk(clk), .rst(rst), .bus(ifc));
   typedef struct packed {logic [11:0] ia; logic [9:0] wa;} exe_t;
   exe_t exp_q[$];
   logic [9:0] oa_q[$];
   int cyc = 0, n_tests = 0, n_fail = 0;
   int kinit_t[$], kfin_t[$], sfin_t[$], exec_t[$];
   logic [11:0] got_ia[$];
   logic [9:0] got_wa[$];
   logic [9:0] last_oa = '0;
   // event recorder and scoreboard, sampled mid-cycle
   always @(negedge clk) begin : mon
      exe_t e;
      logic [9:0] eo;
      cyc++;
      if (rst) begin
         if (ifc.k_init) kinit_t.push_back(cyc);
         if (ifc.s_fin) sfin_t.push_back(cyc);
         if (ifc.k_fin) begin
            kfin_t.push_back(cyc);
            last_oa = ifc.oa;
            n_tests++;
            if (oa_q.size() == 0) begin
               n_fail++;
               $display("FAIL oa_unexpected: got k_fin with oa %0d, expected no window", ifc.oa);
            end else begin
               eo = oa_q.pop_front();
               if (ifc.oa !== eo) begin
                  n_fail++;
                  $display("FAIL oa: got %0d, expected %0d", ifc.oa, eo);
               end
            end
         end
         if (ifc.exec) begin
            exec_t.push_back(cyc);
            got_ia.push_back(ifc.ia);
            got_wa.push_back(ifc.wa);
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL exec_unexpected: got ia %0d wa %0d, expected no exec", ifc.ia, ifc.wa);
            end else begin
               e = exp_q.pop_front();
               if (ifc.ia !== e.ia || ifc.wa !== e.wa) begin
                  n_fail++;
                  $display("FAIL exec_addr: got ia %0d wa %0d, expected ia %0d wa %0d", ifc.ia, ifc.wa, e.ia, e.wa);
               end
            end
         end
      end
   end
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic clr();
      kinit_t.delete(); kfin_t.delete(); sfin_t.delete(); exec_t.delete(); got_ia.delete(); got_wa.delete();
   endtask
   task automatic cfg(input bit md, st, input int owl, ohl, iwl, icl, kl);
      int s, oh, k;
      ifc.mode = md; ifc.stride = st;
      ifc.ow_last = 5'(owl); ifc.oh_last = 5'(ohl); ifc.iw_last = 5'(iwl); ifc.ic_last = 5'(icl); ifc.k_last = 5'(kl);
      s = (md && st) ? 2 : 1;
      oh = md ? ohl : 0;
      k = md ? kl : 0;
      for (int oy = 0; oy <= oh; oy++)
         for (int ox = 0; ox <= owl; ox++) begin
            for (int ky = 0; ky <= k; ky++)
               for (int kx = 0; kx <= k; kx++)
                  for (int ic = 0; ic <= icl; ic++) begin
                     exe_t e;
                     if (md) begin
                        e.ia = 12'(((oy * s + ky) * (iwl + 1) + ox * s + kx) * (icl + 1) + ic);
                        e.wa = 10'((ky * (k + 1) + kx) * (icl + 1) + ic);
                     end else begin
                        e.ia = 12'(ox * (icl + 1) + ic);
                        e.wa = 10'(ic);
                     end
                     exp_q.push_back(e);
                  end
            oa_q.push_back(10'(oy * (owl + 1) + ox));
         end
   endtask
   task automatic start(output int t);
      ifc.s_init = 1'b1;
      t = cyc + 1;
      tick();
      ifc.s_init = 1'b0;
   endtask
   task automatic wait_sfin(input int max);
      for (int i = 0; i < max && sfin_t.size() == 0; i++) tick();
   endtask
   task automatic test_reset();
      rst = 1'b0;
      {ifc.mode, ifc.stride, ifc.s_init, ifc.out_busy, ifc.outrf} = '0;
      {ifc.ow_last, ifc.oh_last, ifc.iw_last, ifc.ic_last, ifc.k_last} = '0;
      tick(3);
      n_tests++;
      if ({ifc.busy, ifc.exec, ifc.k_init, ifc.k_fin, ifc.s_fin} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_strobes: got %b, expected 00000", {ifc.busy, ifc.exec, ifc.k_init, ifc.k_fin, ifc.s_fin});
      end
      n_tests++;
      if ({ifc.ia, ifc.wa, ifc.oa} !== 32'b0) begin
         n_fail++;
         $display("FAIL reset_addr: got ia %0d wa %0d oa %0d, expected 0", ifc.ia, ifc.wa, ifc.oa);
      end
      rst = 1'b1;
      tick();
   endtask
   task automatic test_dense();
      int t;
      clr();
      ifc.outrf = 1'b1; ifc.out_busy = 1'b0;
      cfg(0, 0, 2, 0, 0, 3, 0);
      start(t);
      wait_sfin(100);
      n_tests++;
      if (sfin_t.size() != 1) begin n_fail++; $display("FAIL dense_sfin_seen: got %0d, expected 1", sfin_t.size()); end
      n_tests++;
      if (kinit_t[0] != t + 1) begin n_fail++; $display("FAIL dense_kinit0: got %0d, expected %0d", kinit_t[0], t + 1); end
      n_tests++;
      if (kfin_t.size() != 3) begin n_fail++; $display("FAIL dense_kfin_count: got %0d, expected 3", kfin_t.size()); end
      n_tests++;
      if (kfin_t[0] != t + 6) begin n_fail++; $display("FAIL dense_kfin0: got %0d, expected %0d", kfin_t[0], t + 6); end
      n_tests++;
      if (kinit_t[1] != t + 6) begin n_fail++; $display("FAIL dense_kinit1: got %0d, expected %0d", kinit_t[1], t + 6); end
      n_tests++;
      if (kfin_t[2] != t + 16) begin n_fail++; $display("FAIL dense_kfin2: got %0d, expected %0d", kfin_t[2], t + 16); end
      n_tests++;
      if (sfin_t[0] != t + 17) begin n_fail++; $display("FAIL dense_sfin_time: got %0d, expected %0d", sfin_t[0], t + 17); end
      n_tests++;
      if (exec_t.size() != 12) begin n_fail++; $display("FAIL dense_exec_count: got %0d, expected 12", exec_t.size()); end
      n_tests++;
      if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL dense_busy_after: got %b, expected 0", ifc.busy); end
      n_tests++;
      if (exp_q.size() != 0 || oa_q.size() != 0) begin
         n_fail++; $display("FAIL dense_leftover: got %0d terms %0d windows, expected 0", exp_q.size(), oa_q.size());
      end
   endtask
   task automatic test_conv_s1();
      int t;
      clr();
      cfg(1, 0, 1, 1, 3, 0, 1);
      start(t);
      wait_sfin(100);
      n_tests++;
      if (sfin_t[0] != t + 22) begin n_fail++; $display("FAIL conv1_sfin_time: got %0d, expected %0d", sfin_t[0], t + 22); end
      n_tests++;
      if (last_oa !== 10'd3) begin n_fail++; $display("FAIL conv1_last_oa: got %0d, expected 3", last_oa); end
      n_tests++;
      if (got_ia[12] !== 12'd5 || got_ia[15] !== 12'd10) begin
         n_fail++; $display("FAIL conv1_win3_ia: got %0d..%0d, expected 5..10", got_ia[12], got_ia[15]);
      end
      n_tests++;
      if (exec_t.size() != 16 || exp_q.size() != 0) begin
         n_fail++; $display("FAIL conv1_exec_count: got %0d left %0d, expected 16 left 0", exec_t.size(), exp_q.size());
      end
   endtask
   task automatic test_conv_s2();
      int t;
      clr();
      cfg(1, 1, 1, 0, 4, 1, 2);
      start(t);
      wait_sfin(100);
      n_tests++;
      if (sfin_t[0] != t + 40) begin n_fail++; $display("FAIL conv2_sfin_time: got %0d, expected %0d", sfin_t[0], t + 40); end
      n_tests++;
      if (got_ia[18] !== 12'd4 || got_ia[35] !== 12'd29) begin
         n_fail++; $display("FAIL conv2_win1_ia: got first %0d last %0d, expected 4 and 29", got_ia[18], got_ia[35]);
      end
      n_tests++;
      if (got_wa[18] !== 10'd0 || got_wa[35] !== 10'd17) begin
         n_fail++; $display("FAIL conv2_wa_range: got first %0d last %0d, expected 0 and 17", got_wa[18], got_wa[35]);
      end
      n_tests++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL conv2_leftover: got %0d, expected 0", exp_q.size()); end
   endtask
   task automatic test_back_pressure();
      int t, stall_exec;
      clr();
      cfg(0, 0, 2, 0, 0, 3, 0);
      start(t);
      tick(5);
      ifc.out_busy = 1'b1;
      tick(5);
      ifc.out_busy = 1'b0;
      wait_sfin(100);
      stall_exec = 0;
      foreach (exec_t[i]) if (exec_t[i] >= t + 6 && exec_t[i] <= t + 11) stall_exec++;
      n_tests++;
      if (kfin_t[0] != t + 6) begin n_fail++; $display("FAIL bp_kfin0: got %0d, expected %0d", kfin_t[0], t + 6); end
      n_tests++;
      if (kinit_t[1] != t + 11) begin n_fail++; $display("FAIL bp_kinit1: got %0d, expected %0d", kinit_t[1], t + 11); end
      n_tests++;
      if (stall_exec != 0) begin n_fail++; $display("FAIL bp_stall_exec: got %0d, expected 0", stall_exec); end
      n_tests++;
      if (kfin_t[1] != t + 16) begin n_fail++; $display("FAIL bp_kfin1: got %0d, expected %0d", kfin_t[1], t + 16); end
      n_tests++;
      if (exec_t.size() != 12 || exp_q.size() != 0) begin
         n_fail++; $display("FAIL bp_exec_count: got %0d left %0d, expected 12 left 0", exec_t.size(), exp_q.size());
      end
   endtask
   task automatic test_outrf_delay();
      int t;
      clr();
      ifc.outrf = 1'b0;
      cfg(0, 0, 1, 0, 0, 1, 0);
      start(t);
      tick(9);
      ifc.s_init = 1'b1;
      tick();
      ifc.s_init = 1'b0;
      tick(3);
      n_tests++;
      if (ifc.busy !== 1'b1 || sfin_t.size() != 0) begin
         n_fail++; $display("FAIL outrf_wait: got busy %b sfin %0d, expected busy 1 sfin 0", ifc.busy, sfin_t.size());
      end
      ifc.outrf = 1'b1;
      tick();
      ifc.s_init = 1'b1;
      n_tests++;
      if (ifc.busy !== 1'b1 || ifc.s_fin !== 1'b1) begin
         n_fail++; $display("FAIL outrf_sfin_cycle: got busy %b s_fin %b, expected 1 1", ifc.busy, ifc.s_fin);
      end
      tick();
      ifc.s_init = 1'b0;
      tick(6);
      n_tests++;
      if (sfin_t.size() != 1 || sfin_t[0] != t + 15) begin
         n_fail++; $display("FAIL outrf_sfin_time: got %0d (count %0d), expected %0d", sfin_t[0], sfin_t.size(), t + 15);
      end
      n_tests++;
      if (kinit_t.size() != 2 || ifc.busy !== 1'b0) begin
         n_fail++; $display("FAIL outrf_ignored_init: got %0d windows busy %b, expected 2 busy 0", kinit_t.size(), ifc.busy);
      end
   endtask
   task automatic test_reset_mid();
      int t;
      clr();
      cfg(1, 0, 1, 1, 3, 0, 1);
      start(t);
      tick(3);
      rst = 1'b0;
      exp_q.delete();
      oa_q.delete();
      tick();
      n_tests++;
      if ({ifc.busy, ifc.exec, ifc.k_init, ifc.k_fin, ifc.s_fin} !== 5'b0 || {ifc.ia, ifc.wa, ifc.oa} !== 32'b0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got strobes %b ia %0d wa %0d oa %0d, expected all 0",
                  {ifc.busy, ifc.exec, ifc.k_init, ifc.k_fin, ifc.s_fin}, ifc.ia, ifc.wa, ifc.oa);
      end
      rst = 1'b1;
      clr();
      cfg(0, 0, 1, 0, 0, 1, 0);
      start(t);
      wait_sfin(60);
      n_tests++;
      if (got_ia[0] !== 12'd0 || exec_t.size() != 4) begin
         n_fail++; $display("FAIL midreset_restart: got first ia %0d count %0d, expected 0 and 4", got_ia[0], exec_t.size());
      end
      n_tests++;
      if (sfin_t[0] != t + 8 || exp_q.size() != 0) begin
         n_fail++; $display("FAIL midreset_sfin: got %0d left %0d, expected %0d left 0", sfin_t[0], exp_q.size(), t + 8);
      end
   endtask
   initial begin
      test_reset();
      test_dense();
      test_conv_s1();
      test_conv_s2();
      test_back_pressure();
      test_outrf_delay();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
